// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               Holds the prefetch queue entry layout, the PC step and the
//               NOP encoding the downstream flush mux inserts.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Width of the queue entry fields; the fetch_unit XLEN parameter must match.
    localparam int FETCH_XLEN = 32;

    // Byte distance between consecutive sequential fetches.
    localparam int PC_INC = 4;

    // addi x0, x0, 0 -- what decode sees when the IF/ID register is flushed.
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [FETCH_XLEN-1:0] instr;
        logic [FETCH_XLEN-1:0] pc;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Synchronous FIFO of fetch_entry_t. Pointers carry one extra
//               wrap bit so full and empty are told apart without a separate
//               counter. Flush empties the queue in one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    logic [CW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] rd_ptr_q, rd_ptr_d;
    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          do_push;
    logic          do_pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign count = wr_ptr_q - rd_ptr_q;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Head is read straight out of the registered array: no write-through bypass.
    assign head = mem_q[rd_idx];

    // Next-state pointers and storage; flush overrides any push/pop this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_idx] = push_data;
                wr_ptr_d      = wr_ptr_q + CW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + CW'(1);
            end
        end
    end

    // State registers; storage is cleared so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage. Issues word-aligned requests to the
//               instruction memory under a credit rule sized to the prefetch
//               queue, tags in-order responses with their PC, and hands
//               {instr, pc} pairs to decode. Redirects flush the queue and
//               discard every response still in flight.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fd_valid,
    output logic [XLEN-1:0] fd_instr,
    output logic [XLEN-1:0] fd_pc,
    input  logic            fd_ready
);

    localparam int            CW           = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0]   CREDIT_LIMIT = (CW+1)'(QUEUE_DEPTH);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(PC_INC);

    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q,     resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q,    drop_cnt_d;

    logic [CW-1:0]   q_count;
    logic            q_empty;
    logic            q_full;
    fetch_entry_t    q_head;
    fetch_entry_t    push_entry;

    logic [XLEN-1:0] redirect_target;
    logic [CW:0]     credit_used;
    logic            issue;
    logic            push;
    logic            pop;

    assign redirect_target = redirect_pc & ~XLEN'(3);

    // Every queued entry and every request still in flight holds one credit,
    // so the queue always has room for whatever the memory returns.
    assign credit_used    = {1'b0, q_count} + {1'b0, outstanding_q};
    // rst gates the request combinationally so the bus is quiet during reset.
    assign imem_req_valid = !rst && !halt && (credit_used < CREDIT_LIMIT);
    assign imem_req_addr  = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    // Responses owed to pre-redirect requests, and the one landing in the
    // redirect cycle itself, are wrong-path and never enter the queue.
    assign push = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;

    // Hide the head in the redirect cycle; it is about to be flushed.
    assign fd_valid = !q_empty && !redirect_valid;
    assign pop      = fd_valid && fd_ready;
    assign fd_instr = q_head.instr;
    assign fd_pc    = q_head.pc;

    assign push_entry.instr = imem_resp_data;
    assign push_entry.pc    = resp_pc_q;

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (q_head),
        .empty     (q_empty),
        .full      (q_full),
        .count     (q_count)
    );

    // Next-state PCs and in-flight bookkeeping; a redirect overrides everything.
    always_comb begin
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_resp_valid);
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;

        if (redirect_valid) begin
            // Everything still outstanding after this cycle is wrong-path,
            // including a request accepted in this very cycle.
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            drop_cnt_d = outstanding_d;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                resp_pc_d = resp_pc_q + PC_STEP;
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end
    end

    // PC and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit. An in-order memory model
//               with configurable latency answers requests; a reference model
//               tracks the expected fetch address, the expected next PC seen
//               by decode and the credits in use, and every cycle is compared.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 4;
    localparam int          CW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready = 1'b0;
    logic            imem_resp_valid = 1'b0;
    logic [XLEN-1:0] imem_resp_data = '0;
    logic            redirect_valid = 1'b0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            halt = 1'b0;
    logic            fd_valid;
    logic [XLEN-1:0] fd_instr;
    logic [XLEN-1:0] fd_pc;
    logic            fd_ready = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN        (XLEN),
        .RESET_PC    (RPC),
        .QUEUE_DEPTH (DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .halt            (halt),
        .fd_valid        (fd_valid),
        .fd_instr        (fd_instr),
        .fd_pc           (fd_pc),
        .fd_ready        (fd_ready)
    );

    // Memory model: accepted requests wait here until their due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mreq_t;
    mreq_t mq[$];

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int lat_min = 1;
    int lat_max = 1;
    int last_due = 0;

    // Reference model state
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    int          epoch;
    int          live;       // correct-path requests issued but not yet taken by decode
    int          issued;
    int          delivered;

    // Observations from the most recent step
    logic        s_req;
    logic        s_fdv;
    logic [31:0] s_fdpc;
    logic [31:0] s_addr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic model_reset();
        mq.delete();
        exp_fetch = RPC;
        exp_pc    = RPC;
        epoch     = 0;
        live      = 0;
        issued    = 0;
        delivered = 0;
        last_due  = cyc;
    endtask

    task automatic drive_idle();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        halt            = 1'b0;
        fd_ready        = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock cycle: drive inputs at the falling edge, sample and check
    // mid-cycle, then advance the reference model for what commits at the
    // next rising edge.
    task automatic step(input bit rdy, input bit fdr, input bit hlt,
                        input bit redir, input logic [31:0] rpc);
        int stale;
        int d;
        bit exp_req;
        @(negedge clk);
        stale = 0;
        foreach (mq[i]) if (mq[i].epoch != epoch) stale++;

        n_total++;
        if (dut.outstanding_q !== CW'(mq.size())) begin
            $display("FAIL outstanding: got %0d want %0d", dut.outstanding_q, mq.size());
        end else n_pass++;
        n_total++;
        if (dut.drop_cnt_q !== CW'(stale)) begin
            $display("FAIL drop_cnt: got %0d want %0d", dut.drop_cnt_q, stale);
        end else n_pass++;
        n_total++;
        if (dut.drop_cnt_q > dut.outstanding_q) begin
            $display("FAIL drop_le_outstanding: drop %0d outstanding %0d", dut.drop_cnt_q, dut.outstanding_q);
        end else n_pass++;

        imem_req_ready = rdy;
        fd_ready       = fdr;
        halt           = hlt;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        exp_req = !hlt && ((live + stale) < DEPTH);
        #1;
        s_req  = imem_req_valid;
        s_fdv  = fd_valid;
        s_fdpc = fd_pc;
        s_addr = imem_req_addr;

        n_total++;
        if (imem_req_valid !== exp_req) begin
            $display("FAIL req_valid: got %b want %b (cyc %0d)", imem_req_valid, exp_req, cyc);
        end else n_pass++;
        if (imem_req_valid === 1'b1) begin
            n_total++;
            if (imem_req_addr !== exp_fetch) begin
                $display("FAIL req_addr: got %h want %h", imem_req_addr, exp_fetch);
            end else n_pass++;
        end
        if (redir) begin
            n_total++;
            if (fd_valid !== 1'b0) begin
                $display("FAIL fd_valid_in_redirect: got %b want 0", fd_valid);
            end else n_pass++;
        end
        if (fd_valid === 1'b1) begin
            n_total++;
            if (fd_pc !== exp_pc || fd_instr !== instr_of(exp_pc)) begin
                $display("FAIL fd_head: got pc %h instr %h want pc %h instr %h",
                         fd_pc, fd_instr, exp_pc, instr_of(exp_pc));
            end else n_pass++;
        end

        if (imem_req_valid === 1'b1 && rdy) begin
            d = cyc + int'($urandom_range(lat_max, lat_min));
            if (d < last_due) d = last_due;
            last_due = d;
            mq.push_back('{exp_fetch, d, epoch});
            exp_fetch += 32'd4;
            live++;
            issued++;
        end
        if (fd_valid === 1'b1 && fdr) begin
            exp_pc += 32'd4;
            live--;
            delivered++;
        end
        if (redir) begin
            epoch++;
            live      = 0;
            exp_fetch = rpc & ~32'h3;
            exp_pc    = rpc & ~32'h3;
        end
        cyc++;
    endtask

    task automatic test_reset();
        @(posedge clk);
        @(negedge clk);
        n_total++;
        if (fd_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
            $display("FAIL reset_valids: fd_valid %b req_valid %b want 0 0", fd_valid, imem_req_valid);
        end else n_pass++;
        n_total++;
        if (fd_instr !== 32'h0 || fd_pc !== 32'h0) begin
            $display("FAIL reset_head: instr %h pc %h want 0 0", fd_instr, fd_pc);
        end else n_pass++;
        n_total++;
        if (imem_req_addr !== RPC) begin
            $display("FAIL reset_addr: got %h want %h", imem_req_addr, RPC);
        end else n_pass++;
    endtask

    task automatic test_steady();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 24; i++) begin
            step(1, 1, 0, 0, 32'h0);
            n_total++;
            if (s_fdv !== 1'(i >= 2)) begin
                $display("FAIL steady_bubble: cycle %0d fd_valid %b want %b", i, s_fdv, (i >= 2));
            end else n_pass++;
        end
        n_total++;
        if (delivered != 22) begin
            $display("FAIL steady_count: got %0d want 22", delivered);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 32'h0);
        n_total++;
        if (issued != 4 || s_req !== 1'b0) begin
            $display("FAIL bp_credit: issued %0d req_valid %b want 4 0", issued, s_req);
        end else n_pass++;
        for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 32'h0);
        n_total++;
        if (delivered != 12) begin
            $display("FAIL bp_drain: delivered %0d want 12", delivered);
        end else n_pass++;
    endtask

    task automatic test_redirect();
        bit seen;
        do_reset();
        lat_min = 3; lat_max = 3;
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 32'h40);
        @(posedge clk);
        #1;
        n_total++;
        if (dut.drop_cnt_q !== CW'(2)) begin
            $display("FAIL redir_drop: got %0d want 2", dut.drop_cnt_q);
        end else n_pass++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, 32'h0);
            if (s_fdv === 1'b1 && !seen) begin
                seen = 1;
                n_total++;
                if (s_fdpc !== 32'h40) begin
                    $display("FAIL redir_first_pc: got %h want 00000040", s_fdpc);
                end else n_pass++;
            end
        end
        n_total++;
        if (!seen) begin
            $display("FAIL redir_no_delivery: got none want pc 00000040");
        end else n_pass++;
    endtask

    task automatic test_coincide();
        bit seen;
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 32'h0);
        step(1, 1, 0, 1, 32'h100);
        n_total++;
        if (s_req !== 1'b1 || imem_resp_valid !== 1'b1) begin
            $display("FAIL coincide_setup: req_valid %b resp_valid %b want 1 1", s_req, imem_resp_valid);
        end else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (dut.drop_cnt_q !== CW'(1)) begin
            $display("FAIL coincide_drop: got %0d want 1", dut.drop_cnt_q);
        end else n_pass++;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 0, 0, 32'h0);
            if (s_fdv === 1'b1 && !seen) begin
                seen = 1;
                n_total++;
                if (s_fdpc !== 32'h100) begin
                    $display("FAIL coincide_first_pc: got %h want 00000100", s_fdpc);
                end else n_pass++;
            end
        end
    endtask

    task automatic test_halt();
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 32'h0);
        n_total++;
        if (delivered != 3) begin
            $display("FAIL halt_drain: delivered %0d want 3", delivered);
        end else n_pass++;
        step(1, 1, 0, 0, 32'h0);
        n_total++;
        if (s_req !== 1'b1 || s_addr !== 32'hC) begin
            $display("FAIL halt_resume: req %b addr %h want 1 0000000c", s_req, s_addr);
        end else n_pass++;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 32'h0);
    endtask

    task automatic test_async_reset_wrap();
        do_reset();
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 32'h0);
        n_total++;
        if (s_fdv !== 1'b1) begin
            $display("FAIL areset_setup: fd_valid %b want 1", s_fdv);
        end else n_pass++;
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (fd_valid !== 1'b0 || imem_req_valid !== 1'b0 || fd_instr !== 32'h0 ||
            fd_pc !== 32'h0 || imem_req_addr !== RPC) begin
            $display("FAIL areset_outputs: fdv %b reqv %b instr %h pc %h addr %h want all 0",
                     fd_valid, imem_req_valid, fd_instr, fd_pc, imem_req_addr);
        end else n_pass++;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        step(1, 1, 0, 0, 32'h0);
        n_total++;
        if (s_req !== 1'b1 || s_addr !== RPC) begin
            $display("FAIL areset_first_req: req %b addr %h want 1 %h", s_req, s_addr, RPC);
        end else n_pass++;
        step(0, 1, 0, 1, 32'hFFFF_FFFF);
        step(1, 1, 0, 0, 32'h0);
        n_total++;
        if (s_addr !== 32'hFFFF_FFFC) begin
            $display("FAIL wrap_target: got %h want fffffffc", s_addr);
        end else n_pass++;
        step(1, 1, 0, 0, 32'h0);
        n_total++;
        if (s_addr !== 32'h0) begin
            $display("FAIL wrap_next: got %h want 00000000", s_addr);
        end else n_pass++;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 32'h0);
    endtask

    task automatic test_random();
        bit hlt;
        bit redir;
        logic [31:0] tgt;
        do_reset();
        lat_min = 1; lat_max = 4;
        hlt = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 19) == 0) hlt = !hlt;
            redir = ($urandom_range(0, 24) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, hlt, redir, tgt);
        end
        n_total++;
        if (delivered < 200) begin
            $display("FAIL random_progress: delivered %0d want >= 200", delivered);
        end else n_pass++;
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_steady();
        test_backpressure();
        test_redirect();
        test_coincide();
        test_halt();
        test_async_reset_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
